// File: rtl/alu_m_unit_if.sv
// rtl/alu_m_unit_if.sv - operand/result bundle between execute stage and the M unit.
// div_overflow exists only when ALU_M_OVF_FLAG_EN is defined.
interface alu_m_unit_if;
  logic        in_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic [31:0] result;
  logic        div_by_zero;
`ifdef ALU_M_OVF_FLAG_EN
  logic        div_overflow;
`endif

  modport master (
    output in_valid, rs1, rs2, funct3, funct7,
`ifdef ALU_M_OVF_FLAG_EN
    input  div_overflow,
`endif
    input  out_valid, result, div_by_zero
  );

  modport slave (
    input  in_valid, rs1, rs2, funct3, funct7,
`ifdef ALU_M_OVF_FLAG_EN
    output div_overflow,
`endif
    output out_valid, result, div_by_zero
  );
endinterface

// File: rtl/alu_m_unit.sv
// rtl/alu_m_unit.sv - RV32M multiply/divide unit, single-cycle combinational math, registered result.
// Optional macro ALU_M_OVF_FLAG_EN adds the registered div_overflow flag.
module alu_m_unit #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_m_unit_if.slave m_if
);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic            is_m_op;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic [XLEN:0]   op_a;
  logic [XLEN:0]   op_b;
  logic signed [2*XLEN-1:0] op_a_ext;
  logic signed [2*XLEN-1:0] op_b_ext;
  logic signed [2*XLEN-1:0] product;
  logic [XLEN-1:0] mul_res;

  logic            div_signed;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] uquot;
  logic [XLEN-1:0] urem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] div_res;
  logic            dbz;
  logic            ovf;

  logic [XLEN-1:0] op_result;
  logic            op_dbz;
  logic            op_ovf;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] result_d, result_q;
  logic            div_by_zero_d, div_by_zero_q;
  logic            div_overflow_d, div_overflow_q;

  assign is_m_op = (m_if.funct7 == F7_MULDIV);
  assign is_div  = m_if.funct3[2];

  // MULH treats both operands as signed, MULHSU only rs1; the 33rd bit carries that choice.
  assign a_signed = (m_if.funct3 == F3_MULH) || (m_if.funct3 == F3_MULHSU);
  assign b_signed = (m_if.funct3 == F3_MULH);
  assign op_a     = {a_signed & m_if.rs1[XLEN-1], m_if.rs1};
  assign op_b     = {b_signed & m_if.rs2[XLEN-1], m_if.rs2};
  assign op_a_ext = {{(XLEN-1){op_a[XLEN]}}, op_a};
  assign op_b_ext = {{(XLEN-1){op_b[XLEN]}}, op_b};
  assign product  = op_a_ext * op_b_ext;

  always_comb begin
    mul_res = product[2*XLEN-1:XLEN];
    if (m_if.funct3 == F3_MUL) begin
      mul_res = product[XLEN-1:0];
    end else if (m_if.funct3 == F3_MULHU) begin
      mul_res = product[2*XLEN-1:XLEN];
    end
  end

  // Signed divide works on magnitudes; the most negative value negates to itself,
  // which is exactly what makes the overflow case fall out as 8000_0000 / 0.
  assign div_signed = ~m_if.funct3[0];
  assign neg_a      = div_signed & m_if.rs1[XLEN-1];
  assign neg_b      = div_signed & m_if.rs2[XLEN-1];
  assign mag_a      = neg_a ? (~m_if.rs1 + 1'b1) : m_if.rs1;
  assign mag_b      = neg_b ? (~m_if.rs2 + 1'b1) : m_if.rs2;
  assign dbz        = (m_if.rs2 == '0);
  assign divisor    = dbz ? {{(XLEN-1){1'b0}}, 1'b1} : mag_b;
  assign uquot      = mag_a / divisor;
  assign urem       = mag_a % divisor;
  assign quot       = (neg_a ^ neg_b) ? (~uquot + 1'b1) : uquot;
  assign rem        = neg_a ? (~urem + 1'b1) : urem;
  assign ovf        = div_signed && (m_if.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (m_if.rs2 == {XLEN{1'b1}});

  always_comb begin
    div_res = m_if.funct3[1] ? rem : quot;
    if (dbz) begin
      div_res = m_if.funct3[1] ? m_if.rs1 : {XLEN{1'b1}};
    end
  end

  always_comb begin
    op_result = '0;
    op_dbz    = 1'b0;
    op_ovf    = 1'b0;
    if (is_m_op) begin
      op_result = is_div ? div_res : mul_res;
      op_dbz    = is_div & dbz;
      op_ovf    = is_div & ovf;
    end
  end

  always_comb begin
    out_valid_d    = m_if.in_valid;
    result_d       = result_q;
    div_by_zero_d  = div_by_zero_q;
    div_overflow_d = div_overflow_q;
    if (m_if.in_valid) begin
      result_d       = op_result;
      div_by_zero_d  = op_dbz;
      div_overflow_d = op_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      div_by_zero_q  <= 1'b0;
      div_overflow_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      div_by_zero_q  <= div_by_zero_d;
      div_overflow_q <= div_overflow_d;
    end
  end

  assign m_if.out_valid   = out_valid_q;
  assign m_if.result      = result_q;
  assign m_if.div_by_zero = div_by_zero_q;

`ifdef ALU_M_OVF_FLAG_EN
  assign m_if.div_overflow = div_overflow_q;
`else
  logic unused_ovf;
  assign unused_ovf = div_overflow_q;
`endif

endmodule

// File: tb/tb_alu_m_unit.sv
// tb/tb_alu_m_unit.sv - directed and short random checks for alu_m_unit.
module tb_alu_m_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_m_unit_if u_if ();

  alu_m_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m_if  (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [6:0] f7);
    u_if.in_valid = v;
    u_if.funct3   = f3;
    u_if.rs1      = a;
    u_if.rs2      = b;
    u_if.funct7   = f7;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dbz);
    drive(1'b1, f3, a, b, 7'b0000001);
    chk({tag, "_valid"}, {31'b0, u_if.out_valid}, 32'd1);
    chk({tag, "_res"}, u_if.result, exp_res);
    chk({tag, "_dbz"}, {31'b0, u_if.div_by_zero}, {31'b0, exp_dbz});
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  logic [2:0]  rf3;
  logic [31:0] ra, rb, held;

  initial begin
    rst_n = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.funct3   = 3'd0;
    u_if.rs1      = 32'd3;
    u_if.rs2      = 32'd4;
    u_if.funct7   = 7'b0000001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", {31'b0, u_if.out_valid}, 32'd0);
    chk("rst_res", u_if.result, 32'd0);
    chk("rst_dbz", {31'b0, u_if.div_by_zero}, 32'd0);
    rst_n = 1'b1;

    op("mul_10x20", 3'd0, 32'd10, 32'd20, 32'd200, 1'b0);
    op("mul_m10x5", 3'd0, -32'sd10, 32'd5, 32'hFFFFFFCE, 1'b0);
    op("mulhsu", 3'd2, -32'sd100, 32'd200, 32'hFFFFFFFF, 1'b0);
    op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    op("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);

    op("div_100_20", 3'd4, 32'd100, 32'd20, 32'd5, 1'b0);
    op("divu_100_3", 3'd5, 32'd100, 32'd3, 32'd33, 1'b0);
    op("div_m7_2", 3'd4, -32'sd7, 32'd2, 32'hFFFFFFFD, 1'b0);
    op("rem_m7_2", 3'd6, -32'sd7, 32'd2, 32'hFFFFFFFF, 1'b0);
    op("rem_35_6", 3'd6, 32'd35, 32'd6, 32'd5, 1'b0);
    op("remu_35_4", 3'd7, 32'd35, 32'd4, 32'd3, 1'b0);

    op("div_by0", 3'd4, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b1);
    op("rem_by0", 3'd6, 32'd35, 32'd0, 32'd35, 1'b1);
    op("divu_by0", 3'd5, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b1);
    op("remu_by0", 3'd7, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b1);

    op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
`ifdef ALU_M_OVF_FLAG_EN
    chk("div_ovf_flag", {31'b0, u_if.div_overflow}, 32'd1);
`endif
    op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef ALU_M_OVF_FLAG_EN
    chk("rem_ovf_flag", {31'b0, u_if.div_overflow}, 32'd1);
`endif
    op("divu_noovf", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef ALU_M_OVF_FLAG_EN
    chk("divu_ovf_flag", {31'b0, u_if.div_overflow}, 32'd0);
`endif

    for (int i = 0; i < 20; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 50));
        2: rb = -32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, ref_res(rf3, ra, rb),
         rf3[2] && (rb == 32'd0));
    end

    op("pre_hold", 3'd7, 32'd9, 32'd0, 32'd9, 1'b1);
    held = u_if.result;
    drive(1'b0, 3'd0, 32'd1234, 32'd5678, 7'b0000001);
    chk("hold_valid", {31'b0, u_if.out_valid}, 32'd0);
    chk("hold_res", u_if.result, 32'd9);
    chk("hold_dbz", {31'b0, u_if.div_by_zero}, 32'd1);
    drive(1'b0, 3'd4, 32'd1, 32'd0, 7'b0000001);
    chk("hold2_res", u_if.result, held);

    drive(1'b1, 3'd0, 32'd10, 32'd20, 7'b0000000);
    chk("f7_valid", {31'b0, u_if.out_valid}, 32'd1);
    chk("f7_res", u_if.result, 32'd0);
    chk("f7_dbz", {31'b0, u_if.div_by_zero}, 32'd0);
    drive(1'b1, 3'd4, 32'd10, 32'd0, 7'b0100000);
    chk("f7div_res", u_if.result, 32'd0);
    chk("f7div_dbz", {31'b0, u_if.div_by_zero}, 32'd0);

    drive(1'b1, 3'd0, 32'd6, 32'd7, 7'b0000001);
    rst_n = 1'b0;
    drive(1'b1, 3'd0, 32'd6, 32'd7, 7'b0000001);
    chk("rst2_valid", {31'b0, u_if.out_valid}, 32'd0);
    chk("rst2_res", u_if.result, 32'd0);
    rst_n = 1'b1;
    op("after_rst", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
